// File: rtl/pipelined_adder_n.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES registered chunks
// with a per-stage valid/ready handshake, so bubbles collapse and backpressure ripples back.
module pipelined_adder_n #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic                             cin,
  input  logic                             sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 sum,
  output logic                             cout,
  output logic                             ovf,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             accept;
  logic             out_fire;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO   = gi * CHUNK;
    localparam int HI   = LO + CHUNK;
    localparam int IN_W = WIDTH - LO;

    // Operands arriving here are only the not-yet-consumed upper bits; s_q holds the finished low bits.
    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    logic            c_in;
    logic            v_in;
    logic            down_ready;
    logic            load;
    logic            move;
    logic            capture;
    logic [CHUNK:0]  chunk_sum;
    logic [HI-1:0]   s_new;
    logic [HI-1:0]   s_q;
    logic [HI-1:0]   s_d;
    logic            valid_q;
    logic            valid_d;
    logic            carry_q;
    logic            carry_d;

    if (gi == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub ? ~cin : cin;
      assign v_in  = accept;
      assign s_new = chunk_sum[CHUNK-1:0];
    end else begin : g_next
      assign a_in  = g_stage[gi-1].g_pass.a_q;
      assign b_in  = g_stage[gi-1].g_pass.b_q;
      assign c_in  = g_stage[gi-1].carry_q;
      assign v_in  = g_stage[gi-1].move;
      assign s_new = {chunk_sum[CHUNK-1:0], g_stage[gi-1].s_q};
    end

    assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};
    assign load      = !valid_q || down_ready;
    assign move      = valid_q && down_ready;
    assign capture   = load && v_in;

    always_comb begin
      valid_d = load ? v_in : valid_q;
      s_d     = capture ? s_new : s_q;
      carry_d = capture ? chunk_sum[CHUNK] : carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        s_q     <= '0;
        carry_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        s_q     <= s_d;
        carry_q <= carry_d;
      end
    end

    if (gi == STAGES - 1) begin : g_tail
      logic ovf_q;
      logic ovf_d;

      assign down_ready = out_ready;

      // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      always_comb begin
        ovf_d = ovf_q;
        if (capture) begin
          ovf_d = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_pass
      localparam int REM_W = IN_W - CHUNK;

      logic [REM_W-1:0] a_q;
      logic [REM_W-1:0] a_d;
      logic [REM_W-1:0] b_q;
      logic [REM_W-1:0] b_d;

      assign down_ready = g_stage[gi+1].load;

      always_comb begin
        a_d = capture ? a_in[IN_W-1:CHUNK] : a_q;
        b_d = capture ? b_in[IN_W-1:CHUNK] : b_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign in_ready  = rst_n && g_stage[0].load;
  assign accept    = in_valid && in_ready;
  assign out_fire  = g_stage[STAGES-1].move;
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    case ({accept, out_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
